// File: rtl/snes_port_pkg.sv
// Shared constants and FSM encoding for the SNES controller port host.
package snes_port_pkg;

   localparam int unsigned HALF_DEF      = 6;
   localparam int unsigned LATCH_CYC_DEF = 12;
   localparam int unsigned BITS_DEF      = 16;
   localparam int unsigned CNT_W         = 9;

   // Shadow/JOY slot index for each physical data line.
   localparam int unsigned LINE_P1_D0 = 0;
   localparam int unsigned LINE_P2_D0 = 1;
   localparam int unsigned LINE_P1_D1 = 2;
   localparam int unsigned LINE_P2_D1 = 3;
   localparam int unsigned NUM_LINES  = 4;

   localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
   localparam logic [2:0] ST_LATCH_ENC  = 3'd1;
   localparam logic [2:0] ST_CLK_LO_ENC = 3'd2;
   localparam logic [2:0] ST_CLK_HI_ENC = 3'd3;
   localparam logic [2:0] ST_FINISH_ENC = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE_ENC,
      S_LATCH  = ST_LATCH_ENC,
      S_CLK_LO = ST_CLK_LO_ENC,
      S_CLK_HI = ST_CLK_HI_ENC,
      S_FINISH = ST_FINISH_ENC
   } port_host_state_t;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/snes_port_if.sv
// Physical controller-port bundle: latch/clock out, serial data and IOBit in.
interface snes_port_if;
   logic       PORT_LATCH;
   logic [1:0] PORT_CLK;
   logic [1:0] PORT1_DO;
   logic [1:0] PORT2_DO;
   logic       PORT_P6;

   modport master (output PORT_LATCH, output PORT_CLK,
                   input  PORT1_DO, input PORT2_DO, input PORT_P6);
   modport slave  (input  PORT_LATCH, input PORT_CLK,
                   output PORT1_DO, output PORT2_DO, output PORT_P6);
endinterface

// File: rtl/snes_p6_latch.sv
// Port-2 IOBit falling-edge detector that snapshots the PPU H/V counters.
module snes_p6_latch
   import snes_port_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             PORT_P6,
   input  logic             P6_EN,
   input  logic [CNT_W-1:0] HCNT,
   input  logic [CNT_W-1:0] VCNT,
   input  logic             OPLATCHED_CLR,
   output logic [CNT_W-1:0] OPHCT,
   output logic [CNT_W-1:0] OPVCT,
   output logic             OPLATCHED
);

   logic             sync1_q, sync2_q, prev_q;
   logic             fall;
   logic [CNT_W-1:0] ophct_q, ophct_d, opvct_q, opvct_d;
   logic             oplat_q, oplat_d;

   assign fall = prev_q & ~sync2_q;

   // A qualifying edge takes priority over a simultaneous clear.
   always_comb begin
      ophct_d = ophct_q;
      opvct_d = opvct_q;
      oplat_d = oplat_q;
      if (fall && P6_EN) begin
         ophct_d = HCNT;
         opvct_d = VCNT;
         oplat_d = 1'b1;
      end else if (OPLATCHED_CLR) begin
         oplat_d = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         ophct_q <= '0;
         opvct_q <= '0;
         oplat_q <= 1'b0;
      end else begin
         sync1_q <= PORT_P6;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         ophct_q <= ophct_d;
         opvct_q <= opvct_d;
         oplat_q <= oplat_d;
      end
   end

   assign OPHCT     = ophct_q;
   assign OPVCT     = opvct_q;
   assign OPLATCHED = oplat_q;

endmodule

// File: rtl/snes_port_host.sv
// Console-side controller port master: latch, serial clocking, auto-read of
// four data lines into JOY1-4, plus the IOBit counter latch.
module snes_port_host
   import snes_port_pkg::*;
#(
   parameter int unsigned HALF      = HALF_DEF,
   parameter int unsigned LATCH_CYC = LATCH_CYC_DEF,
   parameter int unsigned BITS      = BITS_DEF
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   output logic [15:0]      JOY1,
   output logic [15:0]      JOY2,
   output logic [15:0]      JOY3,
   output logic [15:0]      JOY4,
   input  logic             P6_EN,
   input  logic [CNT_W-1:0] HCNT,
   input  logic [CNT_W-1:0] VCNT,
   output logic [CNT_W-1:0] OPHCT,
   output logic [CNT_W-1:0] OPVCT,
   output logic             OPLATCHED,
   input  logic             OPLATCHED_CLR,
   snes_port_if.master      port
);

   localparam int unsigned PH_MAX = max_u(HALF, LATCH_CYC);
   localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam int unsigned BC_W   = $clog2(BITS) + 1;

   port_host_state_t                   state_q, state_d;
   logic [PH_W-1:0]                    phase_q, phase_d;
   logic [BC_W-1:0]                    bit_q, bit_d;
   logic [NUM_LINES-1:0][15:0]         sr_q, sr_d;
   logic [NUM_LINES-1:0][15:0]         joy_q, joy_d;
   logic [NUM_LINES-1:0]               lines;

   assign lines[LINE_P1_D0] = port.PORT1_DO[0];
   assign lines[LINE_P2_D0] = port.PORT2_DO[0];
   assign lines[LINE_P1_D1] = port.PORT1_DO[1];
   assign lines[LINE_P2_D1] = port.PORT2_DO[1];

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      joy_d   = joy_q;
      case (state_q)
         S_IDLE: if (START) begin
            state_d = S_LATCH;
            phase_d = PH_W'(LATCH_CYC - 1);
            bit_d   = '0;
         end
         S_LATCH: if (phase_q == '0) begin
            state_d = S_CLK_LO;
            phase_d = PH_W'(HALF - 1);
         end else begin
            phase_d = phase_q - 1'b1;
         end
         S_CLK_LO: if (phase_q == '0) begin
            for (int unsigned i = 0; i < NUM_LINES; i++)
               sr_d[i] = {sr_q[i][14:0], ~lines[i]};
            state_d = S_CLK_HI;
            phase_d = PH_W'(HALF - 1);
         end else begin
            phase_d = phase_q - 1'b1;
         end
         // Copy into JOY on the way to FINISH so the new data and DONE coincide.
         S_CLK_HI: if (phase_q == '0) begin
            if (bit_q == BC_W'(BITS - 1)) begin
               state_d = S_FINISH;
               joy_d   = sr_q;
            end else begin
               state_d = S_CLK_LO;
               phase_d = PH_W'(HALF - 1);
               bit_d   = bit_q + 1'b1;
            end
         end else begin
            phase_d = phase_q - 1'b1;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         phase_q <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         joy_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         joy_q   <= joy_d;
      end
   end

   assign port.PORT_LATCH = (state_q == S_LATCH);
   assign port.PORT_CLK   = (state_q == S_CLK_LO) ? 2'b00 : 2'b11;
   assign BUSY            = (state_q != S_IDLE);
   assign DONE            = (state_q == S_FINISH);
   assign JOY1            = joy_q[LINE_P1_D0];
   assign JOY2            = joy_q[LINE_P2_D0];
   assign JOY3            = joy_q[LINE_P1_D1];
   assign JOY4            = joy_q[LINE_P2_D1];

   snes_p6_latch u_p6 (
      .CLK           (CLK),
      .RESET         (RESET),
      .PORT_P6       (port.PORT_P6),
      .P6_EN         (P6_EN),
      .HCNT          (HCNT),
      .VCNT          (VCNT),
      .OPLATCHED_CLR (OPLATCHED_CLR),
      .OPHCT         (OPHCT),
      .OPVCT         (OPVCT),
      .OPLATCHED     (OPLATCHED)
   );

endmodule

// File: tb/tb_snes_port_host.sv
// Directed bench for snes_port_host with a shift-register pad model on each line.
module tb_snes_port_host;

   logic        CLK, RESET, START, P6_EN, OPLATCHED_CLR, p6_pin;
   logic        BUSY, DONE, OPLATCHED;
   logic [15:0] JOY1, JOY2, JOY3, JOY4;
   logic [8:0]  HCNT, VCNT, OPHCT, OPVCT;
   logic [15:0] dev_pat [4];
   logic [15:0] dev_sr  [4];
   logic        pclk_prev;
   int          pass_cnt = 0;
   int          total    = 0;

   snes_port_if pif ();

   snes_port_host #(.HALF(4), .LATCH_CYC(12), .BITS(16)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .START         (START),
      .BUSY          (BUSY),
      .DONE          (DONE),
      .JOY1          (JOY1),
      .JOY2          (JOY2),
      .JOY3          (JOY3),
      .JOY4          (JOY4),
      .P6_EN         (P6_EN),
      .HCNT          (HCNT),
      .VCNT          (VCNT),
      .OPHCT         (OPHCT),
      .OPVCT         (OPVCT),
      .OPLATCHED     (OPLATCHED),
      .OPLATCHED_CLR (OPLATCHED_CLR),
      .port          (pif)
   );

   // Line index: 0 = P1 DO0, 1 = P2 DO0, 2 = P1 DO1, 3 = P2 DO1; raw active-low levels.
   assign pif.PORT1_DO = {dev_sr[2][15], dev_sr[0][15]};
   assign pif.PORT2_DO = {dev_sr[3][15], dev_sr[1][15]};
   assign pif.PORT_P6  = p6_pin;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      pclk_prev <= pif.PORT_CLK[0];
      for (int i = 0; i < 4; i++) begin
         if (pif.PORT_LATCH)
            dev_sr[i] <= dev_pat[i];
         else if (pif.PORT_CLK[0] && !pclk_prev)
            dev_sr[i] <= {dev_sr[i][14:0], 1'b1};
      end
   end

   task automatic run_sequence(input int restart_at,
                               output int latch_cnt, output int latch_stray,
                               output int lo_pulses, output int lo_cycles,
                               output int done_cnt, output int done_at,
                               output int joy_early, output int busy_bad);
      logic [1:0]  pc;
      logic [63:0] pj;
      latch_cnt = 0; latch_stray = 0; lo_pulses = 0; lo_cycles = 0;
      done_cnt = 0; done_at = 0; joy_early = 0; busy_bad = 0;
      pc = pif.PORT_CLK;
      pj = {JOY1, JOY2, JOY3, JOY4};
      START = 1'b1;
      for (int c = 1; c <= 160; c++) begin
         @(posedge CLK); #1;
         START = (c == restart_at);
         if (pif.PORT_LATCH) begin
            if (c >= 1 && c <= 12) latch_cnt++; else latch_stray++;
         end
         if (pif.PORT_CLK == 2'b00) lo_cycles++;
         if (pif.PORT_CLK == 2'b00 && pc == 2'b11) lo_pulses++;
         pc = pif.PORT_CLK;
         if (DONE) begin
            done_cnt++;
            if (done_at == 0) done_at = c;
         end
         if ({JOY1, JOY2, JOY3, JOY4} !== pj && !DONE) joy_early++;
         pj = {JOY1, JOY2, JOY3, JOY4};
         if (BUSY !== (c <= 141)) busy_bad++;
      end
      START = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      total++; if (pif.PORT_LATCH !== 1'b0) $display("FAIL reset_latch: got %b expected 0", pif.PORT_LATCH); else pass_cnt++;
      total++; if (pif.PORT_CLK !== 2'b11) $display("FAIL reset_clk: got %b expected 11", pif.PORT_CLK); else pass_cnt++;
      total++; if ({BUSY, DONE} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {BUSY, DONE}); else pass_cnt++;
      total++; if ({JOY1, JOY2, JOY3, JOY4} !== 64'h0) $display("FAIL reset_joy: got %h expected 0", {JOY1, JOY2, JOY3, JOY4}); else pass_cnt++;
      total++; if ({OPHCT, OPVCT, OPLATCHED} !== 19'h0) $display("FAIL reset_p6: got %h expected 0", {OPHCT, OPVCT, OPLATCHED}); else pass_cnt++;
      RESET = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_single_read();
      int lc, ls, lp, lcy, dc, da, je, bb;
      dev_pat[0] = 16'hA5C3; dev_pat[1] = 16'hFFFF; dev_pat[2] = 16'hFFFF; dev_pat[3] = 16'hFFFF;
      run_sequence(0, lc, ls, lp, lcy, dc, da, je, bb);
      total++; if (lc !== 12 || ls !== 0) $display("FAIL single_latch: got %0d/%0d expected 12/0", lc, ls); else pass_cnt++;
      total++; if (lp !== 16) $display("FAIL single_clk_pulses: got %0d expected 16", lp); else pass_cnt++;
      total++; if (lcy !== 64) $display("FAIL single_clk_low_cycles: got %0d expected 64", lcy); else pass_cnt++;
      total++; if (dc !== 1 || da !== 141) $display("FAIL single_done: got %0d at %0d expected 1 at 141", dc, da); else pass_cnt++;
      total++; if (bb !== 0) $display("FAIL single_busy: got %0d bad cycles expected 0", bb); else pass_cnt++;
      total++; if (JOY1 !== 16'h5A3C) $display("FAIL single_joy1: got %h expected 5a3c", JOY1); else pass_cnt++;
      total++; if ({JOY2, JOY3, JOY4} !== 48'h0) $display("FAIL single_joy234: got %h expected 0", {JOY2, JOY3, JOY4}); else pass_cnt++;
   endtask

   task automatic test_all_lines();
      int lc, ls, lp, lcy, dc, da, je, bb;
      dev_pat[0] = 16'h0001; dev_pat[1] = 16'h8000; dev_pat[2] = 16'hFFFF; dev_pat[3] = 16'h1234;
      run_sequence(0, lc, ls, lp, lcy, dc, da, je, bb);
      total++; if (JOY1 !== 16'hFFFE) $display("FAIL lines_joy1: got %h expected fffe", JOY1); else pass_cnt++;
      total++; if (JOY2 !== 16'h7FFF) $display("FAIL lines_joy2: got %h expected 7fff", JOY2); else pass_cnt++;
      total++; if (JOY3 !== 16'h0000) $display("FAIL lines_joy3: got %h expected 0000", JOY3); else pass_cnt++;
      total++; if (JOY4 !== 16'hEDCB) $display("FAIL lines_joy4: got %h expected edcb", JOY4); else pass_cnt++;
      total++; if (je !== 0) $display("FAIL lines_joy_partial: got %0d early changes expected 0", je); else pass_cnt++;
      total++; if (da !== 141) $display("FAIL lines_done_at: got %0d expected 141", da); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lc, ls, lp, lcy, dc, da, je, bb;
      dev_pat[0] = 16'h3C3C; dev_pat[1] = 16'h0F0F; dev_pat[2] = 16'hF00F; dev_pat[3] = 16'h5555;
      run_sequence(50, lc, ls, lp, lcy, dc, da, je, bb);
      total++; if (dc !== 1 || da !== 141) $display("FAIL b2b_done: got %0d at %0d expected 1 at 141", dc, da); else pass_cnt++;
      total++; if (lc !== 12 || ls !== 0 || lp !== 16) $display("FAIL b2b_waveform: got %0d/%0d/%0d expected 12/0/16", lc, ls, lp); else pass_cnt++;
      total++; if (bb !== 0) $display("FAIL b2b_busy: got %0d bad cycles expected 0", bb); else pass_cnt++;
      total++; if ({JOY1, JOY4} !== 32'hC3C3AAAA) $display("FAIL b2b_joy: got %h expected c3c3aaaa", {JOY1, JOY4}); else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int lc, ls, lp, lcy, dc, da, je, bb;
      int stray_done;
      dev_pat[0] = 16'hA5C3; dev_pat[1] = 16'hFFFF; dev_pat[2] = 16'hFFFF; dev_pat[3] = 16'hFFFF;
      START = 1'b1;
      for (int c = 1; c <= 70; c++) begin
         @(posedge CLK); #1;
         START = 1'b0;
      end
      RESET = 1'b1;
      @(posedge CLK); #1;
      total++; if (pif.PORT_LATCH !== 1'b0 || pif.PORT_CLK !== 2'b11) $display("FAIL abort_port: got %b/%b expected 0/11", pif.PORT_LATCH, pif.PORT_CLK); else pass_cnt++;
      total++; if (BUSY !== 1'b0) $display("FAIL abort_busy: got %b expected 0", BUSY); else pass_cnt++;
      total++; if ({JOY1, JOY2, JOY3, JOY4} !== 64'h0) $display("FAIL abort_joy: got %h expected 0", {JOY1, JOY2, JOY3, JOY4}); else pass_cnt++;
      RESET = 1'b0;
      stray_done = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge CLK); #1;
         if (DONE) stray_done++;
      end
      total++; if (stray_done !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", stray_done); else pass_cnt++;
      run_sequence(0, lc, ls, lp, lcy, dc, da, je, bb);
      total++; if (da !== 141 || JOY1 !== 16'h5A3C) $display("FAIL abort_rerun: got %0d/%h expected 141/5a3c", da, JOY1); else pass_cnt++;
   endtask

   task automatic test_p6_disabled();
      P6_EN = 1'b0; HCNT = 9'd137; VCNT = 9'd201;
      p6_pin = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      total++; if ({OPHCT, OPVCT, OPLATCHED} !== 19'h0) $display("FAIL p6_disabled: got %h expected 0", {OPHCT, OPVCT, OPLATCHED}); else pass_cnt++;
      p6_pin = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
   endtask

   task automatic test_p6_latch();
      P6_EN = 1'b1; HCNT = 9'd137; VCNT = 9'd201;
      p6_pin = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      total++; if (OPLATCHED !== 1'b0) $display("FAIL p6_early: got %b expected 0", OPLATCHED); else pass_cnt++;
      @(posedge CLK); #1;
      total++; if (OPLATCHED !== 1'b1) $display("FAIL p6_flag: got %b expected 1", OPLATCHED); else pass_cnt++;
      total++; if (OPHCT !== 9'd137 || OPVCT !== 9'd201) $display("FAIL p6_counters: got %0d/%0d expected 137/201", OPHCT, OPVCT); else pass_cnt++;
      p6_pin = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
   endtask

   task automatic test_p6_clear();
      HCNT = 9'd50; VCNT = 9'd60;
      p6_pin = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      OPLATCHED_CLR = 1'b1;
      @(posedge CLK); #1;
      OPLATCHED_CLR = 1'b0;
      total++; if (OPLATCHED !== 1'b1) $display("FAIL clr_vs_edge_flag: got %b expected 1", OPLATCHED); else pass_cnt++;
      total++; if (OPHCT !== 9'd50 || OPVCT !== 9'd60) $display("FAIL clr_vs_edge_counters: got %0d/%0d expected 50/60", OPHCT, OPVCT); else pass_cnt++;
      OPLATCHED_CLR = 1'b1;
      @(posedge CLK); #1;
      OPLATCHED_CLR = 1'b0;
      total++; if (OPLATCHED !== 1'b0) $display("FAIL clr_alone: got %b expected 0", OPLATCHED); else pass_cnt++;
      total++; if (OPHCT !== 9'd50) $display("FAIL clr_keeps_counter: got %0d expected 50", OPHCT); else pass_cnt++;
   endtask

   initial begin
      RESET = 1'b1; START = 1'b0; P6_EN = 1'b0; OPLATCHED_CLR = 1'b0; p6_pin = 1'b1;
      HCNT = '0; VCNT = '0;
      for (int i = 0; i < 4; i++) dev_pat[i] = 16'hFFFF;
      test_reset();
      test_single_read();
      test_all_lines();
      test_back_to_back();
      test_reset_abort();
      test_p6_disabled();
      test_p6_latch();
      test_p6_clear();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
